// File: rtl/nasti_stream_tx_pkg.sv
// Shared types and helpers for the stream packet transmitter.
// Holds the FSM state encoding and the packet-length clamp.
package nasti_stream_tx_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   // Longest packet the buffer can hold is buf_size beats (len = buf_size-1).
   function automatic int unsigned clamp_len(
      input int unsigned len,
      input int unsigned buf_size
   );
      return (len > buf_size - 1) ? buf_size - 1 : len;
   endfunction

endpackage

// File: rtl/nasti_stream_channel.sv
// AXI4-Stream style channel bundle.
// Master drives the payload and t_valid, slave drives t_ready.
interface nasti_stream_channel #(
   parameter int ID_WIDTH   = 1,
   parameter int DEST_WIDTH = 1,
   parameter int USER_WIDTH = 1,
   parameter int DATA_WIDTH = 64
);
   logic                    t_valid;
   logic                    t_ready;
   logic [DATA_WIDTH-1:0]   t_data;
   logic [DATA_WIDTH/8-1:0] t_strb;
   logic [DATA_WIDTH/8-1:0] t_keep;
   logic                    t_last;
   logic [ID_WIDTH-1:0]     t_id;
   logic [DEST_WIDTH-1:0]   t_dest;
   logic [USER_WIDTH-1:0]   t_user;

   modport master (
      output t_valid, t_data, t_strb, t_keep,
      output t_last, t_id, t_dest, t_user,
      input  t_ready
   );

   modport slave (
      input  t_valid, t_data, t_strb, t_keep,
      input  t_last, t_id, t_dest, t_user,
      output t_ready
   );
endinterface

// File: rtl/nasti_stream_tx.sv
// Host-loaded packet transmitter: buffers up to BUF_SIZE beats and
// emits them as one stream packet on a send command.
module nasti_stream_tx
   import nasti_stream_tx_pkg::*;
#(
   parameter int ID_WIDTH   = 1,
   parameter int DEST_WIDTH = 1,
   parameter int USER_WIDTH = 1,
   parameter int DATA_WIDTH = 64,
   parameter int BUF_SIZE   = 8,
   localparam int BUF_WIDTH  = $clog2(BUF_SIZE),
   localparam int KEEP_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  wr_en,
   input  logic [BUF_WIDTH-1:0]  wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [KEEP_WIDTH-1:0] wr_keep,
   input  logic                  send,
   input  logic [BUF_WIDTH-1:0]  send_len,
   input  logic [ID_WIDTH-1:0]   send_id,
   input  logic [DEST_WIDTH-1:0] send_dest,
   input  logic [USER_WIDTH-1:0] send_user,
   output logic                  busy,
   output logic                  done,
   nasti_stream_channel.master   dest
);

   localparam logic [BUF_WIDTH:0] BUF_LIMIT = (BUF_WIDTH + 1)'(BUF_SIZE);

   state_t                state;
   logic [BUF_WIDTH-1:0]  cnt;
   logic [BUF_WIDTH-1:0]  cnt_nxt;
   logic [BUF_WIDTH-1:0]  len;
   logic [BUF_WIDTH-1:0]  len_c;
   logic [BUF_WIDTH-1:0]  rd_addr;
   logic                  accept;
   logic                  fire;
   logic                  wr_ok;
   logic                  bypass;
   logic [DATA_WIDTH-1:0] ld_data;
   logic [KEEP_WIDTH-1:0] ld_keep;

   logic [DATA_WIDTH-1:0] mem_data [BUF_SIZE];
   logic [KEEP_WIDTH-1:0] mem_keep [BUF_SIZE];

   assign busy    = (state == SEND);
   assign accept  = (state == IDLE) && send;
   assign fire    = dest.t_valid && dest.t_ready;
   assign cnt_nxt = cnt + 1'b1;
   assign len_c   = BUF_WIDTH'(clamp_len(32'(send_len), 32'(BUF_SIZE)));

   // Entry 0 is loaded on accept, otherwise the beat after the current one.
   assign rd_addr = accept ? '0 : cnt_nxt;
   assign wr_ok   = wr_en && ({1'b0, wr_addr} < BUF_LIMIT);
   assign bypass  = wr_ok && (wr_addr == rd_addr);
   assign ld_data = bypass ? wr_data : mem_data[rd_addr];
   assign ld_keep = bypass ? wr_keep : mem_keep[rd_addr];

   // Host write port into the packet buffer; contents survive reset.
   always_ff @(posedge aclk) begin
      if (wr_ok) begin
         mem_data[wr_addr] <= wr_data;
         mem_keep[wr_addr] <= wr_keep;
      end
   end

   // Packet FSM with registered stream outputs.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state        <= IDLE;
         cnt          <= '0;
         len          <= '0;
         done         <= 1'b0;
         dest.t_valid <= 1'b0;
         dest.t_last  <= 1'b0;
         dest.t_data  <= '0;
         dest.t_strb  <= '0;
         dest.t_keep  <= '0;
         dest.t_id    <= '0;
         dest.t_dest  <= '0;
         dest.t_user  <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (send) begin
                  state        <= SEND;
                  cnt          <= '0;
                  len          <= len_c;
                  dest.t_valid <= 1'b1;
                  dest.t_last  <= (len_c == '0);
                  dest.t_data  <= ld_data;
                  dest.t_strb  <= ld_keep;
                  dest.t_keep  <= ld_keep;
                  dest.t_id    <= send_id;
                  dest.t_dest  <= send_dest;
                  dest.t_user  <= send_user;
               end
            end
            SEND: begin
               if (fire) begin
                  if (cnt == len) begin
                     state        <= IDLE;
                     done         <= 1'b1;
                     dest.t_valid <= 1'b0;
                     dest.t_last  <= 1'b0;
                  end else begin
                     cnt         <= cnt_nxt;
                     dest.t_last <= (cnt_nxt == len);
                     dest.t_data <= ld_data;
                     dest.t_strb <= ld_keep;
                     dest.t_keep <= ld_keep;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
